ram_access_ctrl: RTL
====================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 4, RAM data width.
REQ-003 Parameter RD_LAT, default 1, cycles from RAM read-strobe cycle to valid ram_dout; legal range 1..4.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_wr  in  1  1 = single write, 0 = burst read.
REQ-009 req_addr  in  ADDR_W  start address.
REQ-010 req_wdata  in  DATA_W  write data; ignored for reads.
REQ-011 req_len  in  4  read beats minus one (0..15); ignored for writes.
REQ-012 rsp_valid  out  1  rsp_data holds one read beat.
REQ-013 rsp_data  out  DATA_W  read data beat.
REQ-014 rsp_last  out  1  final beat of a burst; high only with rsp_valid.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 ram_cs, ram_wr, ram_rd  out  1 each  RAM chip select, write strobe, read strobe.
REQ-017 ram_addr  out  ADDR_W; ram_din  out  DATA_W; ram_dout  in  DATA_W  RAM address, write data, read data.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DRAIN.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 Acceptance SHALL occur on an edge where req_valid and req_ready are both 1; req_wr, req_addr, req_wdata and req_len are latched at that edge.
REQ-022 Write accepted at edge k: in cycle k+1, state WRITE, ram_cs=1, ram_wr=1, ram_rd=0, ram_addr=latched addr, ram_din=latched data; then IDLE, with req_ready=1 in cycle k+2.
REQ-023 Read accepted at edge k: state READ for cycles k+1..k+1+len; each cycle ram_cs=1, ram_rd=1, ram_wr=0, ram_addr=start+beat index modulo 2^ADDR_W (0xFF wraps to 0x00).
REQ-024 ram_wr and ram_rd SHALL never be 1 together; ram_cs=0, ram_wr=0 and ram_rd=0 in IDLE and DRAIN.
REQ-025 For a ram_rd cycle t: ram_dout sampled at end of cycle t+RD_LAT; rsp_valid=1 and rsp_data=that value in cycle t+RD_LAT+1, exactly one cycle per beat.
REQ-026 Beats SHALL be delivered in address order, contiguous, with no response backpressure.
REQ-027 rsp_last=1 with the beat from the final ram_rd cycle; len=0 gives one beat with rsp_last=1.
REQ-028 After the final ram_rd cycle, state SHALL be DRAIN until the final beat is emitted; IDLE (req_ready=1) in the cycle after rsp_last.
REQ-029 req_valid during busy SHALL be ignored; the host holds the request until acceptance.
REQ-030 The beat counter SHALL be 4 bits; address increments wrap silently, with no error.
REQ-031 Read-after-write to the same address SHALL return the newly written data (writes complete before the next acceptance).

Reset
REQ-032 While rst_n=0, regardless of clk: state=IDLE and every output=0, except req_ready=1 after release; applies mid-burst.
REQ-033 Reset SHALL discard in-flight read beats; no rsp_valid after release until a new read is accepted.
REQ-034 First acceptance is possible on the first rising edge with rst_n=1.

Verification
REQ-035 Write 0x1@0x01, then 0x2@0x02 -> ram_wr pulses one cycle each, ram_addr 0x01 then 0x02, ram_din 0x1 then 0x2; req_ready low exactly one cycle per write.
REQ-036 Read addr 0x01 len=1 after REQ-035 (RD_LAT=1) -> ram_rd in cycles k+1, k+2 at 0x01, 0x02; rsp 0x1 at k+3, 0x2 at k+4 with rsp_last; req_ready at k+5.
REQ-037 Read addr 0xFE len=2 -> ram_addr 0xFE, 0xFF, 0x00; three beats, rsp_last on third only.
REQ-038 Read len=15 with RD_LAT=3 -> 16 contiguous ram_rd cycles; 16 rsp_valid beats starting 4 cycles after first ram_rd; busy high until cycle after rsp_last.
REQ-039 rst_n asserted low during the 5th read beat -> all outputs 0 immediately; after release, no stray rsp_valid; a following write of 0xA@0x10 completes normally.
REQ-040 req_valid held high continuously with alternating write/read -> no request lost or duplicated; ram_wr and ram_rd never overlap; each response matches the last value written to that address.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - host request/response and RAM bus bundle for ram_access_ctrl
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_len;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;
  logic              ram_cs;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Host side plus the RAM model: drives requests and RAM read data.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_len, ram_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy,
    input  ram_cs, ram_wr, ram_rd, ram_addr, ram_din
  );

  // Controller side.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_len, ram_dout,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy,
    output ram_cs, ram_wr, ram_rd, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - host-to-SRAM access controller: single writes, burst reads
module ram_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1   // RAM read latency in cycles, 1..4
) (
  input logic              clk,
  input logic              rst_n,
  ram_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] din_q, din_nxt;
  logic              cs_q, cs_nxt;
  logic              wr_q, wr_nxt;
  logic              rd_q, rd_nxt;
  logic [3:0]        len_q, len_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic              idle_q;
  logic              busy_q;

  // One flag per outstanding read cycle, aged once per clock; the tap at
  // RD_LAT-1 lines up with the cycle in which ram_dout is valid.
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Next-state and next-output decode; RAM strobes are computed one cycle
  // ahead so they can come straight out of flops.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    din_nxt   = din_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          addr_nxt = bus.req_addr;
          cs_nxt   = 1'b1;
          if (bus.req_wr) begin
            state_nxt = WRITE;
            wr_nxt    = 1'b1;
            din_nxt   = bus.req_wdata;
          end else begin
            state_nxt = READ;
            rd_nxt    = 1'b1;
            len_nxt   = bus.req_len;
            cnt_nxt   = 4'd0;
          end
        end
      end
      WRITE: state_nxt = IDLE;
      READ: begin
        if (cnt_q == len_q) begin
          state_nxt = DRAIN;
        end else begin
          cs_nxt   = 1'b1;
          rd_nxt   = 1'b1;
          cnt_nxt  = cnt_q + 4'd1;
          addr_nxt = addr_q + ADDR_W'(1);   // wraps silently at the top
        end
      end
      DRAIN: begin
        if (rsp_last_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered RAM-side / status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      din_q  <= '0;
      len_q  <= 4'd0;
      cnt_q  <= 4'd0;
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      idle_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      din_q  <= din_nxt;
      len_q  <= len_nxt;
      cnt_q  <= cnt_nxt;
      cs_q   <= cs_nxt;
      wr_q   <= wr_nxt;
      rd_q   <= rd_nxt;
      idle_q <= (state_nxt == IDLE);
      busy_q <= (state_nxt != IDLE);
    end
  end

  // Read-return pipeline: capture ram_dout when the matching read matures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      last_pipe   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      vld_pipe[0]  <= rd_q;
      last_pipe[0] <= rd_q && (cnt_q == len_q);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      rsp_valid_q <= vld_pipe[RD_LAT-1];
      rsp_last_q  <= last_pipe[RD_LAT-1];
      if (vld_pipe[RD_LAT-1]) rsp_data_q <= bus.ram_dout;
    end
  end

  // idle_q resets high, so masking with rst_n holds req_ready low during reset
  // yet lets the very first edge after release accept a request.
  assign bus.req_ready = idle_q & rst_n;
  assign bus.busy      = busy_q;
  assign bus.ram_cs    = cs_q;
  assign bus.ram_wr    = wr_q;
  assign bus.ram_rd    = rd_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
